idma_rd_sync_resi_rdata_merge: RTL and testbench

IDMA_RD_SYNC_RESI_RDATA_MERGE -- requirements
Module: idma_rd_sync_resi_rdata_merge

---
 rtl/idma_rd_sync_resi_rdata_merge.sv | 129 ++++++++++++
 tb/tb_idma_rd_sync_resi_rdata_merge.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_rd_sync_resi_rdata_merge.sv
// Residual merge of alternating fmapA/fmapB read beats into
// lane-wise saturated int8 sums with per-pair write addresses.
module idma_rd_sync_resi_rdata_merge (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rd_req,
    input  logic         rd_resi_mode,
    input  logic [15:0]  rd_resi_loop_num,
    input  logic [31:0]  rd_resi_waddr_base,
    input  logic [15:0]  rd_resi_addr_gap,
    input  logic         rdata_valid,
    input  logic [127:0] rdata,
    output logic         rdata_ready,
    output logic         resi_wvalid,
    input  logic         resi_wready,
    output logic [127:0] resi_wdata,
    output logic [31:0]  resi_waddr,
    output logic         resi_wlast,
    output logic         resi_busy,
    output logic         resi_done
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_A,
        WAIT_B
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [15:0]  loop_last;
    logic [15:0]  pair_cnt;
    logic [31:0]  gap_q;
    logic [31:0]  addr_acc;
    logic [127:0] a_buf;
    logic [127:0] sum;
    logic         start;
    logic         beat_hs;
    logic         out_hs;
    logic         is_last;

    function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {a[7], a} + {b[7], b};
        if (s[8] != s[7]) begin
            return s[8] ? 8'h80 : 8'h7f;
        end
        return s[7:0];
    endfunction

    assign start   = (state == IDLE) && !resi_busy && rd_req && rd_resi_mode;
    assign beat_hs = rdata_valid && rdata_ready;
    assign out_hs  = resi_wvalid && resi_wready;
    assign is_last = (pair_cnt == loop_last);

    always_comb begin
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            sum[i*8 +: 8] = sat8(a_buf[i*8 +: 8], rdata[i*8 +: 8]);
        end
    end

    always_comb begin
        state_nxt   = state;
        rdata_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = WAIT_A;
            end
            WAIT_A: begin
                rdata_ready = 1'b1;
                if (rdata_valid) state_nxt = WAIT_B;
            end
            WAIT_B: begin
                // B may only land once the output register can take the sum
                rdata_ready = !resi_wvalid || resi_wready;
                if (rdata_valid && rdata_ready) begin
                    state_nxt = is_last ? IDLE : WAIT_A;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            loop_last   <= '0;
            pair_cnt    <= '0;
            gap_q       <= '0;
            addr_acc    <= '0;
            a_buf       <= '0;
            resi_wvalid <= 1'b0;
            resi_wdata  <= '0;
            resi_waddr  <= '0;
            resi_wlast  <= 1'b0;
            resi_busy   <= 1'b0;
            resi_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            resi_done <= out_hs && resi_wlast;
            if (start) begin
                loop_last <= (rd_resi_loop_num == 16'd0) ? 16'd0
                                                         : rd_resi_loop_num - 16'd1;
                gap_q     <= {16'd0, rd_resi_addr_gap};
                addr_acc  <= rd_resi_waddr_base;
                pair_cnt  <= '0;
                resi_busy <= 1'b1;
            end
            if (out_hs && resi_wlast) begin
                resi_busy <= 1'b0;
            end
            if (state == WAIT_A && beat_hs) begin
                a_buf <= rdata;
            end
            if (state == WAIT_B && beat_hs) begin
                resi_wvalid <= 1'b1;
                resi_wdata  <= sum;
                resi_waddr  <= addr_acc;
                resi_wlast  <= is_last;
                addr_acc    <= addr_acc + gap_q;
                if (!is_last) pair_cnt <= pair_cnt + 16'd1;
            end else if (out_hs) begin
                resi_wvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_idma_rd_sync_resi_rdata_merge.sv
// Bench for the residual merge: queue model of expected results
// plus directed scenarios with literal expectations.
module tb_idma_rd_sync_resi_rdata_merge;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd_req;
    logic         rd_resi_mode;
    logic [15:0]  rd_resi_loop_num;
    logic [31:0]  rd_resi_waddr_base;
    logic [15:0]  rd_resi_addr_gap;
    logic         rdata_valid;
    logic [127:0] rdata;
    logic         rdata_ready;
    logic         resi_wvalid;
    logic         resi_wready;
    logic [127:0] resi_wdata;
    logic [31:0]  resi_waddr;
    logic         resi_wlast;
    logic         resi_busy;
    logic         resi_done;

    idma_rd_sync_resi_rdata_merge dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_resi_mode(rd_resi_mode),
        .rd_resi_loop_num(rd_resi_loop_num), .rd_resi_waddr_base(rd_resi_waddr_base),
        .rd_resi_addr_gap(rd_resi_addr_gap), .rdata_valid(rdata_valid), .rdata(rdata),
        .rdata_ready(rdata_ready), .resi_wvalid(resi_wvalid), .resi_wready(resi_wready),
        .resi_wdata(resi_wdata), .resi_waddr(resi_waddr), .resi_wlast(resi_wlast),
        .resi_busy(resi_busy), .resi_done(resi_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic [31:0]  a;
        logic         l;
    } exp_t;

    exp_t         eq[$];
    logic [127:0] ja[$];
    logic [127:0] jb[$];
    logic [127:0] got_d[$];
    logic [31:0]  got_a[$];
    logic         got_l[$];
    int           nchk = 0;
    int           nerr = 0;
    logic         pend_done = 1'b0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [127:0] sat_model(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] r;
        int x;
        int y;
        int s;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            x = $signed(a[i*8 +: 8]);
            y = $signed(b[i*8 +: 8]);
            s = x + y;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            r[i*8 +: 8] = 8'(s);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pend_done = 1'b0;
        end else begin
            chk("done_timing", {127'd0, resi_done}, {127'd0, pend_done});
            pend_done = resi_wvalid && resi_wready && resi_wlast;
            if (resi_wvalid && resi_wready) begin
                got_d.push_back(resi_wdata);
                got_a.push_back(resi_waddr);
                got_l.push_back(resi_wlast);
                if (eq.size() == 0) begin
                    chk("unexpected_result", 128'd1, 128'd0);
                end else begin
                    e = eq.pop_front();
                    chk("wdata", resi_wdata, e.d);
                    chk("waddr", {96'd0, resi_waddr}, {96'd0, e.a});
                    chk("wlast", {127'd0, resi_wlast}, {127'd0, e.l});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic job(input int n, input logic [31:0] base, input logic [15:0] gap);
        int eff;
        exp_t e;
        eff = (n == 0) ? 1 : n;
        got_d.delete();
        got_a.delete();
        got_l.delete();
        for (int i = 0; i < eff; i++) begin
            e.d = sat_model(ja[i], jb[i]);
            e.a = base + 32'(i) * {16'd0, gap};
            e.l = (i == eff - 1);
            eq.push_back(e);
        end
        rd_req = 1'b1;
        rd_resi_mode = 1'b1;
        rd_resi_loop_num = 16'(n);
        rd_resi_waddr_base = base;
        rd_resi_addr_gap = gap;
        tick();
        rd_req = 1'b0;
        @(negedge clk);
        chk("busy_after_start", {127'd0, resi_busy}, 128'd1);
        tick();
    endtask

    task automatic send(input logic [127:0] d);
        int n;
        rdata_valid = 1'b1;
        rdata = d;
        n = 0;
        @(negedge clk);
        while (!rdata_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!rdata_ready) chk("beat_timeout", 128'd1, 128'd0);
        tick();
        rdata_valid = 1'b0;
    endtask

    task automatic send_all(input int n);
        int eff;
        eff = (n == 0) ? 1 : n;
        for (int i = 0; i < eff; i++) begin
            send(ja[i]);
            send(jb[i]);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!resi_done && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("done_seen", {127'd0, resi_done}, 128'd1);
        chk("busy_at_done", {127'd0, resi_busy}, 128'd0);
        chk("queue_drained", 128'(eq.size()), 128'd0);
        tick();
    endtask

    task automatic fill_rand(input int n);
        ja.delete();
        jb.delete();
        for (int i = 0; i < n; i++) begin
            ja.push_back({$urandom, $urandom, $urandom, $urandom});
            jb.push_back({$urandom, $urandom, $urandom, $urandom});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        rd_req = 1'b0;
        rd_resi_mode = 1'b0;
        rd_resi_loop_num = '0;
        rd_resi_waddr_base = '0;
        rd_resi_addr_gap = '0;
        rdata_valid = 1'b0;
        rdata = '0;
        resi_wready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_wvalid", {127'd0, resi_wvalid}, 128'd0);
        chk("rst_wdata", resi_wdata, 128'd0);
        chk("rst_busy", {127'd0, resi_busy}, 128'd0);
        chk("rst_ready", {127'd0, rdata_ready}, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // model pins
        chk("model_sat_hi", sat_model(128'h7f, 128'h01), 128'h7f);
        chk("model_sat_lo", sat_model(128'h80, 128'hff), 128'h80);
        chk("model_zero", sat_model(128'h05, 128'hfb), 128'h00);

        // idle beats ignored, no start without mode
        rdata_valid = 1'b1;
        rd_req = 1'b1;
        tick();
        rdata_valid = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {127'd0, resi_busy}, 128'd0);
        chk("idle_ready", {127'd0, rdata_ready}, 128'd0);
        tick();

        // basic two-pair job
        ja = '{{16{8'h01}}, {16{8'h10}}};
        jb = '{{16{8'h02}}, {16{8'h20}}};
        job(2, 32'h1000, 16'h40);
        send_all(2);
        wait_done();
        chk("s1_count", 128'(got_d.size()), 128'd2);
        if (got_d.size() == 2) begin
            chk("s1_d0", got_d[0], {16{8'h03}});
            chk("s1_a0", {96'd0, got_a[0]}, 128'h1000);
            chk("s1_d1", got_d[1], {16{8'h30}});
            chk("s1_a1", {96'd0, got_a[1]}, 128'h1040);
            chk("s1_l1", {127'd0, got_l[1]}, 128'd1);
        end

        // saturation lanes
        ja = '{128'hc0_40_05_80_7f};
        jb = '{128'hc0_40_fb_ff_01};
        job(1, 32'h500, 16'h10);
        send_all(1);
        wait_done();
        if (got_d.size() == 1) chk("s2_sat", got_d[0], 128'h80_7f_00_80_7f);

        // output stall: next A accepted, B held off
        fill_rand(2);
        resi_wready = 1'b0;
        job(2, 32'h3000, 16'h100);
        send(ja[0]);
        send(jb[0]);
        send(ja[1]);
        rdata_valid = 1'b1;
        rdata = jb[1];
        repeat (5) begin
            @(negedge clk);
            chk("stall_ready_low", {127'd0, rdata_ready}, 128'd0);
            chk("stall_pending", {127'd0, resi_wvalid}, 128'd1);
            tick();
        end
        resi_wready = 1'b1;
        send(jb[1]);
        wait_done();
        chk("s3_count", 128'(got_d.size()), 128'd2);

        // address wrap
        fill_rand(3);
        job(3, 32'hffff_ffe0, 16'h20);
        send_all(3);
        wait_done();
        if (got_a.size() == 3) begin
            chk("wrap_a0", {96'd0, got_a[0]}, 128'hffff_ffe0);
            chk("wrap_a1", {96'd0, got_a[1]}, 128'h0);
            chk("wrap_a2", {96'd0, got_a[2]}, 128'h20);
        end

        // loop_num zero, mid-job request ignored
        fill_rand(1);
        job(0, 32'h2000, 16'h10);
        rd_req = 1'b1;
        rd_resi_loop_num = 16'd5;
        rd_resi_waddr_base = 32'h9999_0000;
        tick();
        rd_req = 1'b0;
        send_all(0);
        wait_done();
        chk("s5_count", 128'(got_d.size()), 128'd1);
        if (got_d.size() == 1) begin
            chk("s5_last", {127'd0, got_l[0]}, 128'd1);
            chk("s5_addr", {96'd0, got_a[0]}, 128'h2000);
        end

        // reset mid-job with pending output
        fill_rand(2);
        resi_wready = 1'b0;
        job(2, 32'h4000, 16'h8);
        send(ja[0]);
        send(jb[0]);
        send(ja[1]);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_wvalid", {127'd0, resi_wvalid}, 128'd0);
        chk("mid_rst_wdata", resi_wdata, 128'd0);
        chk("mid_rst_waddr", {96'd0, resi_waddr}, 128'd0);
        chk("mid_rst_wlast", {127'd0, resi_wlast}, 128'd0);
        chk("mid_rst_busy", {127'd0, resi_busy}, 128'd0);
        chk("mid_rst_done", {127'd0, resi_done}, 128'd0);
        chk("mid_rst_ready", {127'd0, rdata_ready}, 128'd0);
        eq.delete();
        tick();
        rst_n = 1'b1;
        resi_wready = 1'b1;
        repeat (2) tick();
        chk("post_rst_no_done", {127'd0, resi_done}, 128'd0);
        fill_rand(2);
        job(2, 32'h6000, 16'h10);
        send_all(2);
        wait_done();
        chk("s6_count", 128'(got_d.size()), 128'd2);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
